fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 115 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`timescale 1ns/1ps
// fetch_unit: in-order instruction fetch front end. Issues word fetches,
// remembers the address of every outstanding fetch, parks returned words in a
// small buffer for decode, and squashes stale responses after a redirect.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        Stall,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] InstrF,
   output logic [31:0] PCPlus4F,
   output logic        ValidF
);
   localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
   localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);
   localparam logic [31:0]   NOP     = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   logic [31:0]   pc_q;
   logic [31:0]   pend_pc [DEPTH];
   logic [PW-1:0] pend_wr_q, pend_rd_q;
   logic [CW-1:0] infl_q, drop_q, cnt_q;
   ent_t          ibuf_q [DEPTH];
   logic [PW-1:0] hd_q, tl_q;
   logic [CW:0]   occ;
   logic          fire, push, pop, drop_now;
   ent_t          head;
   logic          unused_tgt_lsb;

   function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
      return (p == LAST) ? '0 : p + PW'(1);
   endfunction

   // Outstanding fetches are counted against buffer space, so a granted
   // request always has a slot waiting when its response returns.
   assign occ       = {1'b0, infl_q} + {1'b0, cnt_q};
   assign imem_req  = rst_n & ~PCSrcE & (occ < DEPTH_C);
   assign imem_addr = pc_q;
   assign fire      = imem_req & imem_gnt;

   assign drop_now  = (drop_q != '0);
   assign push      = imem_rvalid & ~drop_now & ~PCSrcE;
   assign ValidF    = (cnt_q != '0);
   assign pop       = ValidF & ~Stall & ~PCSrcE;

   assign head      = ibuf_q[hd_q];
   assign InstrF    = ValidF ? head.instr : NOP;
   assign PCPlus4F  = ValidF ? head.pc + 32'd4 : 32'h0;

   // Target is word aligned; the low bits are ignored.
   assign unused_tgt_lsb = ^PCTargetE[1:0];

   // Fetch PC, outstanding count, squash count and address-queue pointers.
   // The address queue keeps advancing on squashed responses so later
   // responses stay paired with their own fetch address.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q      <= RESET_PC;
         infl_q    <= '0;
         drop_q    <= '0;
         pend_wr_q <= '0;
         pend_rd_q <= '0;
      end else begin
         if (PCSrcE)    pc_q <= {PCTargetE[31:2], 2'b00};
         else if (fire) pc_q <= pc_q + 32'd4;
         infl_q <= infl_q + CW'(fire) - CW'(imem_rvalid);
         // Everything still outstanding after a redirect is stale; the
         // response landing in the redirect cycle is already excluded.
         if (PCSrcE)                        drop_q <= infl_q - CW'(imem_rvalid);
         else if (imem_rvalid && drop_now)  drop_q <= drop_q - CW'(1);
         if (fire)        pend_wr_q <= nxt(pend_wr_q);
         if (imem_rvalid) pend_rd_q <= nxt(pend_rd_q);
      end
   end

   // Instruction buffer pointers and occupancy; a redirect empties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hd_q  <= '0;
         tl_q  <= '0;
         cnt_q <= '0;
      end else if (PCSrcE) begin
         hd_q  <= '0;
         tl_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push) tl_q <= nxt(tl_q);
         if (pop)  hd_q <= nxt(hd_q);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
   end

   // Storage for outstanding addresses and buffered instructions (no reset
   // needed: entries are only read once their valid tracking says so).
   always_ff @(posedge clk) begin
      if (fire) pend_pc[pend_wr_q] <= pc_q;
      if (push) ibuf_q[tl_q] <= '{instr: imem_rdata, pc: pend_pc[pend_rd_q]};
   end

endmodule
